// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes shared by the EX stage and the state encoding
// of the multi-cycle multiply/divide sequencer.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_DIV = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: unsigned shift-add multiply / restoring divide datapath
// with sign fix-up of the result.
//   load     : latch operand magnitudes and signs, clear accumulator
//   step     : perform one iteration (multiply or divide per is_div)
//   is_div   : selects divide behaviour for load, step and fix-up
//   op_a/b   : two's complement operands (sampled on load)
//   res_hi_c : hi result after the current step, sign-corrected
//   res_lo_c : lo result after the current step, sign-corrected
module muldiv_iter_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] res_hi_c,
  output logic [WIDTH-1:0] res_lo_c
);

  localparam int unsigned W2 = 2 * WIDTH;

  // acc: upper product half / partial remainder; sr: multiplier / quotient
  logic [WIDTH-1:0] acc, sr, mc;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] acc_nxt, sr_nxt, a_mag, b_mag;
  logic [WIDTH:0]   sum, trial, diff;
  logic [W2-1:0]    prod;

  // Magnitude of the most-negative value wraps to 2^(WIDTH-1) as unsigned
  assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
  assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;

  // One iteration of the selected algorithm
  always_comb begin
    acc_nxt = acc;
    sr_nxt  = sr;
    sum     = '0;
    trial   = '0;
    diff    = '0;
    if (is_div) begin
      trial = {acc, sr[WIDTH-1]};
      diff  = trial - {1'b0, mc};
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        sr_nxt  = {sr[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = trial[WIDTH-1:0];
        sr_nxt  = {sr[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum     = {1'b0, acc} + (sr[0] ? {1'b0, mc} : '0);
      acc_nxt = sum[WIDTH:1];
      sr_nxt  = {sum[0], sr[WIDTH-1:1]};
    end
  end

  // Sign correction applied to the post-step values so the sequencer can
  // register the result on the same edge as the final iteration
  always_comb begin
    prod     = {acc_nxt, sr_nxt};
    res_hi_c = '0;
    res_lo_c = '0;
    if (is_div) begin
      res_lo_c = (sign_a ^ sign_b) ? -sr_nxt : sr_nxt;
      res_hi_c = sign_a ? -acc_nxt : acc_nxt;
    end else begin
      if (sign_a ^ sign_b) prod = -prod;
      res_hi_c = prod[W2-1:WIDTH];
      res_lo_c = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      sr     <= '0;
      mc     <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      sr     <= is_div ? a_mag : b_mag;
      mc     <= is_div ? b_mag : a_mag;
      sign_a <= op_a[WIDTH-1];
      sign_b <= op_b[WIDTH-1];
    end else if (step) begin
      acc <= acc_nxt;
      sr  <= sr_nxt;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: EX-stage controller for iterative signed multiply and
// divide. Stalls the pipeline while busy and delivers a 2*WIDTH result.
//   clk, reset  : clock, asynchronous active-high reset
//   start       : request valid; alu_op selects OP_MUL / OP_DIV
//   op_a, op_b  : multiplicand/dividend, multiplier/divisor
//   flush       : abort any in-flight operation
//   stall       : hold EX and earlier stages (combinational)
//   done        : one-cycle pulse, hi/lo valid from this cycle
//   hi, lo      : Mul product halves / Div remainder, quotient
//   div_by_zero : set by a divide with op_b==0, cleared on next accept
module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    counter;
  logic             is_mul_op, is_div_op, accept, busy, is_div;
  logic [WIDTH-1:0] res_hi_c, res_lo_c;

  assign is_mul_op = (alu_op == OP_MUL);
  assign is_div_op = (alu_op == OP_DIV);
  assign accept    = (state == IDLE) && start && !flush && (is_mul_op || is_div_op);
  assign busy      = (state == MUL) || (state == DIV);
  // flush does not drop stall in the cycle it arrives
  assign stall     = busy || accept;
  assign is_div    = busy ? (state == DIV) : is_div_op;

  muldiv_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (busy),
    .is_div   (is_div),
    .op_a     (op_a),
    .op_b     (op_b),
    .res_hi_c (res_hi_c),
    .res_lo_c (res_lo_c)
  );

  // Sequencer FSM with registered results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            counter     <= CW'(WIDTH - 1);
            div_by_zero <= 1'b0;
            if (is_div_op && (op_b == '0)) begin
              // Divide by zero skips iteration entirely
              state       <= DONE;
              done        <= 1'b1;
              hi          <= op_a;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              state <= is_div_op ? DIV : MUL;
            end
          end
        end
        MUL, DIV: begin
          if (flush) begin
            state <= IDLE;
          end else if (counter == '0) begin
            state <= DONE;
            done  <= 1'b1;
            hi    <= res_hi_c;
            lo    <= res_lo_c;
          end else begin
            counter <= counter - CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: table-driven directed test of muldiv_sequencer plus
// hand-written flush, reset and ignored-request sequences.
module tb_muldiv_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alu_op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edz;
    int          lat;
    int          inj;  // cycle at which an ignored OP_DIV start is injected, 0 = none
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  logic [31:0] prev_hi, prev_lo;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_op      (alu_op),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .stall       (stall),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge and follow it to done
  task automatic run_op(input int idx, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat, input int inj);
    int k;
    bit seen;
    @(negedge clk);
    start = 1'b1; alu_op = op; op_a = a; op_b = b;
    #1 check($sformatf("v%0d stall_T", idx), 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    seen = 1'b0;
    while (k <= 100) begin
      if (inj != 0 && k == inj) begin
        start = 1'b1; alu_op = OP_DIV; op_a = 32'd100; op_b = 32'd0;
      end else begin
        start = 1'b0;
      end
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (stall !== 1'b1) check($sformatf("v%0d stall_busy k=%0d", idx, k), 64'(stall), 64'd1);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check($sformatf("v%0d done_seen", idx), 64'(seen), 64'd1);
    check($sformatf("v%0d latency", idx), 64'(k), 64'(elat));
    check($sformatf("v%0d hi", idx), 64'(hi), 64'(ehi));
    check($sformatf("v%0d lo", idx), 64'(lo), 64'(elo));
    check($sformatf("v%0d div_by_zero", idx), 64'(div_by_zero), 64'(edz));
    check($sformatf("v%0d stall_done", idx), 64'(stall), 64'd0);
    @(negedge clk);
    #1;
    check($sformatf("v%0d done_one_cycle", idx), 64'(done), 64'd0);
    check($sformatf("v%0d idle_after", idx), 64'(stall), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_MUL, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 3};
    vecs[1]  = '{OP_MUL, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 0};
    vecs[2]  = '{OP_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 0};
    vecs[3]  = '{OP_DIV, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1,  0};
    vecs[4]  = '{OP_MUL, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 33, 0};
    vecs[5]  = '{OP_DIV, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 0};
    vecs[6]  = '{OP_DIV, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33, 0};
    vecs[7]  = '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33, 0};
    vecs[8]  = '{OP_MUL, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 1'b0, 33, 0};
    vecs[9]  = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33, 0};
    vecs[10] = '{OP_DIV, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1, 1,  0};
    vecs[11] = '{OP_MUL, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 33, 0};

    reset = 1'b1; start = 1'b0; alu_op = OP_ADD; op_a = '0; op_b = '0; flush = 1'b0;
    #22;
    check("reset stall", 64'(stall), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Non-mul/div code: ignored, no stall
    @(negedge clk);
    start = 1'b1; alu_op = OP_ADD; op_a = 32'd1; op_b = 32'd2;
    #1 check("add stall_T", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("add idle stall c%0d", i), 64'(stall), 64'd0);
      check($sformatf("add idle done c%0d", i), 64'(done), 64'd0);
      @(negedge clk);
    end

    for (int i = 0; i < NV; i++)
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo,
             vecs[i].edz, vecs[i].lat, vecs[i].inj);
    prev_hi = vecs[NV-1].ehi;
    prev_lo = vecs[NV-1].elo;

    // Flush at T+5 of a Mul: back to IDLE, no done, results kept
    @(negedge clk);
    start = 1'b1; alu_op = OP_MUL; op_a = 32'd3; op_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    #1 check("flush stall_in_flush_cycle", 64'(stall), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush idle stall", 64'(stall), 64'd0);
    check("flush done", 64'(done), 64'd0);
    begin
      int dcount;
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) dcount++;
      end
      check("flush no_done", 64'(dcount), 64'd0);
    end
    check("flush hi kept", 64'(hi), 64'(prev_hi));
    check("flush lo kept", 64'(lo), 64'(prev_lo));

    // flush with start blocks the accept
    @(negedge clk);
    start = 1'b1; flush = 1'b1; alu_op = OP_DIV; op_a = 32'd9; op_b = 32'd0;
    #1 check("flush+start stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush+start not accepted", 64'(stall), 64'd0);
    check("flush+start no done", 64'(done), 64'd0);
    check("flush+start dz", 64'(div_by_zero), 64'd0);

    // Reset in the middle of a Mul clears everything at once
    @(negedge clk);
    start = 1'b1; alu_op = OP_MUL; op_a = 32'd11; op_b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset stall", 64'(stall), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int dcount;
      dcount = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done || stall) dcount++;
      end
      check("midreset quiet", 64'(dcount), 64'd0);
    end

    run_op(99, OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
